// File: rtl/toggle_sync_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// toggle_sync_rx: receive side of a toggle pulse crossing; single-slot event
// with valid/ready, ack toggle back to the sender, event count, sticky ovf. Rev 1.0
// ----------------------------------------------------------------------------
module toggle_sync_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgl_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ack_tgl,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   tgl_seen_q;
  logic                   tgl_edge;
  logic                   handshake;
  logic                   evt_valid_q;
  logic                   ack_tgl_q;
  logic                   ovf_q;
  logic [CNT_W-1:0]       evt_cnt_q;
  logic [CNT_W-1:0]       evt_cnt_d;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], tgl_in};
  assign tgl_edge  = sync_q[SYNC_STAGES-1] ^ tgl_seen_q;
  assign handshake = evt_valid_q & evt_ready;
  assign evt_cnt_d = evt_cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      tgl_seen_q  <= 1'b0;
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      ack_tgl_q   <= 1'b0;
      ovf_q       <= 1'b0;
      evt_cnt_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      tgl_seen_q <= sync_q[SYNC_STAGES-1];
      // A drop later in this block overrides the clear, so set wins.
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (tgl_edge) begin
            state_q     <= PEND;
            evt_valid_q <= 1'b1;
          end
        end
        PEND: begin
          if (handshake) begin
            ack_tgl_q <= ~ack_tgl_q;
            evt_cnt_q <= evt_cnt_d;
            if (!tgl_edge) begin
              state_q     <= IDLE;
              evt_valid_q <= 1'b0;
            end
          end else if (tgl_edge) begin
            ovf_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign ack_tgl   = ack_tgl_q;
  assign ovf       = ovf_q;
  assign evt_cnt   = evt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_sync_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_toggle_sync_rx: scenario tasks plus a handshake scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
module tb_toggle_sync_rx;

  localparam int CNT_W = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             tgl_in    = 1'b0;
  logic             evt_ready = 1'b0;
  logic             ovf_clr   = 1'b0;
  logic             evt_valid;
  logic             ack_tgl;
  logic             ovf;
  logic [CNT_W-1:0] evt_cnt;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ack;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             sb_e;
  logic [CNT_W-1:0] m_cnt   = '0;
  logic             m_ack   = 1'b0;
  logic             hs_prev = 1'b0;
  int               n_tests = 0;
  int               n_fail  = 0;

  toggle_sync_rx #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgl_in   (tgl_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .ack_tgl  (ack_tgl),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .evt_cnt  (evt_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: each handshake seen at one negedge is checked at the next one.
  always @(negedge clk) begin
    if (hs_prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_hs: got cnt=%0d ack=%0b, want no handshake", evt_cnt, ack_tgl);
      end else begin
        sb_e = exp_q.pop_front();
        if (evt_cnt !== sb_e.cnt || ack_tgl !== sb_e.ack) begin
          n_fail++;
          $display("FAIL sb_handshake: got cnt=%0d ack=%0b, want cnt=%0d ack=%0b",
                   evt_cnt, ack_tgl, sb_e.cnt, sb_e.ack);
        end
      end
    end
    hs_prev = evt_valid && evt_ready && !rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flip(input bit consume);
    tgl_in = ~tgl_in;
    if (consume) begin
      m_cnt = m_cnt + 1'b1;
      m_ack = ~m_ack;
      exp_q.push_back({m_cnt, m_ack});
    end
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    tgl_in    = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    exp_q.delete();
    m_cnt     = '0;
    m_ack     = 1'b0;
    cyc(n);
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    n_tests++;
    if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_tgl); end
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_tests++;
    if (evt_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", evt_cnt); end
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      n_tests++;
      if ({evt_valid, ack_tgl, ovf, evt_cnt} !== 7'd0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: got v=%b a=%b o=%b c=%0d want all 0",
                 i, evt_valid, ack_tgl, ovf, evt_cnt);
      end
    end
  endtask

  task automatic test_basic();
    evt_ready = 1'b1;
    flip(1'b1);
    cyc(2);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", evt_valid); end
    cyc(1);
    n_tests++;
    if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", evt_valid); end
    cyc(1);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", evt_valid); end
    n_tests++;
    if (ack_tgl !== 1'b1 || evt_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_ack_cnt: got ack=%b cnt=%0d want ack=1 cnt=1", ack_tgl, evt_cnt);
    end
    evt_ready = 1'b0;
    cyc(3);
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    flip(1'b1);
    cyc(3);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b want 1", i, evt_valid); end
      if (i < 6) cyc(1);
    end
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    n_tests++;
    if (evt_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b o=%b want v=0 o=0", evt_valid, ovf);
    end
    n_tests++;
    if (ack_tgl !== m_ack || evt_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL bp_ack_cnt: got ack=%b cnt=%0d want ack=%b cnt=%0d", ack_tgl, evt_cnt, m_ack, m_cnt);
    end
    cyc(3);
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    flip(1'b1);
    cyc(6);
    flip(1'b0);
    cyc(2);
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", ovf); end
    cyc(1);
    n_tests++;
    if (ovf !== 1'b1 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got o=%b v=%b want o=1 v=1", ovf, evt_valid);
    end
    cyc(1);
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    n_tests++;
    if (evt_valid !== 1'b0 || evt_cnt !== m_cnt || ack_tgl !== m_ack) begin
      n_fail++;
      $display("FAIL ovf_drop: got v=%b cnt=%0d ack=%b want v=0 cnt=%0d ack=%b",
               evt_valid, evt_cnt, ack_tgl, m_cnt, m_ack);
    end
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    // Drop and clear in the same cycle: the drop must win.
    cyc(2);
    flip(1'b1);
    cyc(3);
    flip(1'b0);
    cyc(2);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    n_tests++;
    if (ovf !== 1'b0 || evt_valid !== 1'b0 || evt_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL ovf_recover: got o=%b v=%b cnt=%0d want o=0 v=0 cnt=%0d", ovf, evt_valid, evt_cnt, m_cnt);
    end
    cyc(3);
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c0;
    logic             a0;
    c0 = m_cnt;
    a0 = m_ack;
    evt_ready = 1'b0;
    flip(1'b1);
    cyc(3);
    flip(1'b1);
    cyc(2);
    evt_ready = 1'b1;
    cyc(1);
    n_tests++;
    if (evt_valid !== 1'b1 || ovf !== 1'b0 || evt_cnt !== c0 + 4'd1 || ack_tgl !== ~a0) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b o=%b cnt=%0d ack=%b want v=1 o=0 cnt=%0d ack=%b",
               evt_valid, ovf, evt_cnt, ack_tgl, c0 + 4'd1, ~a0);
    end
    cyc(1);
    evt_ready = 1'b0;
    n_tests++;
    if (evt_valid !== 1'b0 || evt_cnt !== c0 + 4'd2 || ack_tgl !== a0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b cnt=%0d ack=%b o=%b want v=0 cnt=%0d ack=%b o=0",
               evt_valid, evt_cnt, ack_tgl, ovf, c0 + 4'd2, a0);
    end
    cyc(3);
  endtask

  task automatic test_wrap_reset();
    do_reset(2);
    evt_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      flip(1'b1);
      cyc(4);
    end
    evt_ready = 1'b0;
    n_tests++;
    if (evt_cnt !== 4'd1 || ack_tgl !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_cnt: got cnt=%0d ack=%b want cnt=1 ack=1", evt_cnt, ack_tgl);
    end
    flip(1'b0);
    cyc(3);
    n_tests++;
    if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pending: got %b want 1", evt_valid); end
    do_reset(1);
    n_tests++;
    if ({evt_valid, ack_tgl, ovf, evt_cnt} !== 7'd0) begin
      n_fail++;
      $display("FAIL midrst: got v=%b a=%b o=%b c=%0d want all 0", evt_valid, ack_tgl, ovf, evt_cnt);
    end
    cyc(5);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got %b want 0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_wrap_reset();
    cyc(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expectations want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
